// File: rtl/mode_select_if.sv
// Button-to-mode bus for the LED animation control stage.
//
// Carries the raw push-button into mode_select and the resulting mode
// information back out to the animation top level.
//   btn_raw      raw, bouncy, asynchronous button (1 = pressed)
//   mode         current animation mode (0 shift, 1 block-shift, 2/3 PWM)
//   mode_strobe  one-cycle pulse on every change of mode
//   btn_state    debounced button level
//   long_press   one-cycle pulse when a press crosses the long-press time
//
// The master side drives the button and observes the results.
// The slave side is the mode_select block itself.
interface mode_select_if;
    logic       btn_raw;
    logic [1:0] mode;
    logic       mode_strobe;
    logic       btn_state;
    logic       long_press;

    modport master (
        output btn_raw,
        input  mode,
        input  mode_strobe,
        input  btn_state,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output mode,
        output mode_strobe,
        output btn_state,
        output long_press
    );
endinterface

// File: rtl/mode_select.sv
// Upstream control stage for the LED animation top level.
//
// Turns one raw push-button into the 2-bit animation mode. The button is
// synchronised and debounced. A short press advances the mode and wraps
// after the last mode. A long press forces mode 0. Every mode change comes
// with a one-cycle strobe so the consumer can restart its timers.
//
// Ports:
//   clk  system clock; all logic runs on its rising edge
//   rst  synchronous, active-low reset (0 = reset)
//   sel  mode_select_if slave port:
//        btn_raw in; mode, mode_strobe, btn_state, long_press out
module mode_select #(
    parameter int DB_CYCLES   = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int NUM_MODES   = 4
) (
    input  logic          clk,
    input  logic          rst,
    mode_select_if.slave  sel
);

    localparam logic [CNT_W-1:0] DB_LIM    = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       LAST_MODE = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    state_t           state;
    logic             s1;
    logic             btn_s;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;
    logic [1:0]       mode_q;
    logic             mode_strobe_q;
    logic             btn_state_q;
    logic             long_press_q;

    // Synchroniser, debounce FSM and mode register in one registered block.
    // Pulses default low every cycle. long_done remembers that the current
    // press already acted as a long press, so its release must not also
    // advance the mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1            <= 1'b0;
            btn_s         <= 1'b0;
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            mode_q        <= 2'd0;
            mode_strobe_q <= 1'b0;
            btn_state_q   <= 1'b0;
            long_press_q  <= 1'b0;
        end else begin
            s1            <= sel.btn_raw;
            btn_s         <= s1;
            mode_strobe_q <= 1'b0;
            long_press_q  <= 1'b0;

            unique case (state)
                IDLE: begin
                    btn_state_q <= 1'b0;
                    if (btn_s) begin
                        state  <= DB_PRESS;
                        db_cnt <= CNT_ONE;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LIM) begin
                        state       <= PRESSED;
                        btn_state_q <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= CNT_ONE;
                    end else if (hold_cnt != LONG_LIM) begin
                        // Saturating hold timer; the long-press action fires
                        // on the edge where it reaches the threshold.
                        hold_cnt <= hold_cnt + CNT_ONE;
                        if ((hold_cnt == LONG_LIM - CNT_ONE) && !long_done) begin
                            long_press_q <= 1'b1;
                            long_done    <= 1'b1;
                            if (mode_q != 2'd0) begin
                                mode_q        <= 2'd0;
                                mode_strobe_q <= 1'b1;
                            end
                        end
                    end
                end

                DB_RELEASE: begin
                    // A bounce back high returns to PRESSED with hold_cnt
                    // untouched, so release bounce cannot restart long timing.
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LIM) begin
                        state       <= IDLE;
                        btn_state_q <= 1'b0;
                        long_done   <= 1'b0;
                        if (!long_done) begin
                            mode_q        <= (mode_q == LAST_MODE) ? 2'd0 : mode_q + 2'd1;
                            mode_strobe_q <= 1'b1;
                        end
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sel.mode        = mode_q;
    assign sel.mode_strobe = mode_strobe_q;
    assign sel.btn_state   = btn_state_q;
    assign sel.long_press  = long_press_q;

endmodule

// File: tb/tb_mode_select.sv
// Self-checking bench for mode_select.
//
// Drives directed press patterns followed by random button activity and
// compares every output on every cycle against a behavioural model. The
// model views debouncing as "the synchronised button has disagreed with the
// accepted level for DB_CYCLES+1 consecutive samples", and a long press as
// "LONG_CYCLES cycles held while the accepted level is high and settled".
module tb_mode_select;

    localparam int DB        = 4;
    localparam int LONG      = 20;
    localparam int NUM_MODES = 4;

    logic clk;
    logic rst;

    mode_select_if sel ();

    mode_select #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG),
        .CNT_W      (26),
        .NUM_MODES  (NUM_MODES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vector_count;
    int miscompare_count;

    // Reference model state.
    int m_s1, m_bs;
    int m_level;
    int m_run;
    int m_hold;
    int m_done;
    int m_mode;
    int m_strobe;
    int m_long;

    // Compare one observed value against its expected value and report.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        vector_count++;
        if (actual != expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic stepModel(input int rst_v, input int raw_v);
        int bs_seen;
        if (rst_v == 0) begin
            m_s1 = 0; m_bs = 0; m_level = 0; m_run = 0; m_hold = 0;
            m_done = 0; m_mode = 0; m_strobe = 0; m_long = 0;
        end else begin
            bs_seen  = m_bs;
            m_bs     = m_s1;
            m_s1     = raw_v;
            m_strobe = 0;
            m_long   = 0;
            if (bs_seen != m_level) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_run = 0;
                    if (bs_seen == 1) begin
                        m_level = 1;
                        m_hold  = 0;
                    end else begin
                        m_level = 0;
                        if (m_done == 0) begin
                            m_mode   = (m_mode + 1) % NUM_MODES;
                            m_strobe = 1;
                        end
                        m_done = 0;
                    end
                end
            end else begin
                if (m_level == 1 && m_run == 0 && m_hold < LONG) begin
                    m_hold++;
                    if (m_hold == LONG && m_done == 0) begin
                        m_long = 1;
                        m_done = 1;
                        if (m_mode != 0) begin
                            m_mode   = 0;
                            m_strobe = 1;
                        end
                    end
                end
                m_run = 0;
            end
        end
    endtask

    // Hold rst and btn_raw for n cycles, checking all outputs after each edge.
    task automatic applyStimulus(input logic rst_v, input logic raw_v, input int n);
        for (int i = 0; i < n; i++) begin
            rst         = rst_v;
            sel.btn_raw = raw_v;
            @(posedge clk);
            stepModel(int'(rst_v), int'(raw_v));
            #1;
            checkOutput("mode",        int'(sel.mode),        m_mode);
            checkOutput("mode_strobe", int'(sel.mode_strobe), m_strobe);
            checkOutput("btn_state",   int'(sel.btn_state),   m_level);
            checkOutput("long_press",  int'(sel.long_press),  m_long);
        end
    endtask

    // Directed scenarios first, then random activity with occasional resets.
    initial begin
        int len;
        int lvl;
        vector_count     = 0;
        miscompare_count = 0;
        rst              = 1'b0;
        sel.btn_raw      = 1'b0;
        stepModel(0, 0);

        // Reset with the button held, then release reset with it low.
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 5);

        // Glitch too short to debounce.
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 10);

        // One clean short press: mode 0 -> 1.
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);

        // Back to mode 0, then four short presses; the third one bounces on release.
        applyStimulus(1'b0, 1'b0, 2);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 1'b1, 10);
            if (p == 2) begin
                applyStimulus(1'b1, 1'b0, 3);
                applyStimulus(1'b1, 1'b1, 2);
            end
            applyStimulus(1'b1, 1'b0, 10);
        end

        // Reach mode 2, long press to mode 0, then a long press at mode 0.
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 40);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 40);
        applyStimulus(1'b1, 1'b0, 10);

        // Reset in the middle of a press at mode 1, button kept held after it.
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 12);
        applyStimulus(1'b1, 1'b0, 10);

        // Random bouncy presses of mixed length, with rare resets.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
            end
            lvl = (k % 2 == 0) ? 1 : 0;
            case ($urandom_range(0, 3))
                0:       len = int'($urandom_range(1, 5));
                1:       len = int'($urandom_range(6, 12));
                2:       len = int'($urandom_range(13, 30));
                default: len = int'($urandom_range(30, 45));
            endcase
            applyStimulus(1'b1, 1'(lvl), len);
        end
        applyStimulus(1'b1, 1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
